// File: rtl/key_injector_if.sv
// key_injector_if: valid/ready handshake carrying 5-bit letter codes into the key injector
interface key_injector_if;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_ready;
  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/key_injector.sv
// key_injector: FIFO-buffered letter feeder emitting one-cycle one-hot pulses spaced by GAP idle cycles
module key_injector #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  key_injector_if.slave            kif,
  output logic [25:0]              key_out,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_GAP} state_e;
  state_e        state_q, state_d;
  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    gap_q, gap_d;
  logic [25:0]   key_q, key_d;
  logic          err_q, push, push_ok, pop, fire_ok;
  assign kif.key_ready = cnt_q < CW'(DEPTH);
  assign push    = kif.key_valid && kif.key_ready;
  assign push_ok = push && (kif.key_code < 5'd26);
  assign cnt_d   = cnt_q + CW'(push_ok) - CW'(pop);
  // Only the registered count is consulted, so a same-edge push is never popped early.
  always_comb begin
    fire_ok = (state_q == S_IDLE) || (state_q == S_FIRE && GAP == 0) ||
              (state_q == S_GAP && gap_q == 4'd1);
    pop     = fire_ok && (cnt_q != '0);
    key_d   = pop ? (26'd1 << mem_q[rd_q]) : '0;
    state_d = pop ? S_FIRE :
              (state_q == S_FIRE && GAP > 0) ? S_GAP :
              fire_ok ? S_IDLE : state_q;
    gap_d   = (state_q == S_FIRE) ? 4'(GAP) :
              (state_q == S_GAP) ? gap_q - 4'd1 : gap_q;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      gap_q   <= '0;
      key_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      err_q   <= push && !push_ok;
      wr_q    <= wr_q + AW'(push_ok);
      rd_q    <= rd_q + AW'(pop);
      cnt_q   <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (resetn && push_ok) mem_q[wr_q] <= kif.key_code;
  end
  assign key_out = key_q;
  assign err     = err_q;
  assign count   = cnt_q;
  assign busy    = (state_q != S_IDLE) || (cnt_q != '0);
endmodule

// File: doc/key_injector.md
Name: key_injector

Overview:
- Upstream feeder for the rotor/reflector assembly.
- Accepts 5-bit letter codes (0=A … 25=Z) over a valid/ready handshake and buffers them in a small FIFO.
- Drives each letter onto the assembly's 26-bit one-hot input as a single-cycle pulse. Each pulse steps the rotors exactly once.
- Enforces a configurable all-zero gap between pulses so rotor state settles before the next letter.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- GAP, 2, minimum number of all-zero key_out cycles between consecutive pulses; 0..15.

Ports:
- clk  input  1  system clock, rising-edge.
- resetn  input  1  synchronous active-low reset.
- key_code  input  5  letter code of offered key.
- key_valid  input  1  key_code is valid this cycle.
- key_ready  output  1  FIFO can accept; a transfer occurs when key_valid && key_ready at a rising edge.
- key_out  output  26  one-hot letter pulse to the rotor assembly; bit n = letter n.
- busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.
- err  output  1  one-cycle pulse: an accepted code was ≥26 and was dropped.

Behaviour:
- **Reset:** all state is sampled at the rising edge with resetn=0. This includes mid-pulse and mid-gap. After reset:
  - key_out=0, err=0, count=0, FIFO pointers=0, FSM=IDLE, gap counter=0.
  - key_ready=1 in the first cycle after reset release.
- **key_ready:** combinational, equals (count < DEPTH). When full, no push is accepted even if a pop occurs the same edge.
- **Push:**
  - Code 0..25 accepted: written at the tail; count increments. If a pop occurs the same edge, count is unchanged.
  - Code ≥26 accepted: handshake completes but nothing is written. err=1 for the following cycle only; count unaffected by that code.
- **Visibility of new entries:** an entry written at edge E is visible to the FSM at edge E+1. There is no same-edge bypass.
- **FSM states:** IDLE, FIRE, GAP.
  - **IDLE:** key_out=0.
    - If count>0 at an edge: key_out <= one-hot(head), pop, go to FIRE.
  - **FIRE:** key_out holds the pulse for exactly one cycle. At the next edge key_out <= 0, then:
    - GAP>0: gap counter <= GAP, go to GAP.
    - GAP=0 and count>0: immediately issue the next pulse (key_out <= one-hot(head), pop, stay in FIRE).
    - GAP=0 and count=0: go to IDLE.
  - **GAP:** key_out=0; gap counter decrements each edge. On the edge where the counter is 1:
    - count>0: issue the next pulse (go to FIRE).
    - Otherwise: go to IDLE.
- **Pulse spacing:**
  - Pulses are exactly one cycle wide.
  - Consecutive pulses from a backlogged FIFO have exactly GAP zero cycles between them.
  - key_out is never multi-hot and never carries a partial code.
- **Latency:** handshake at edge E0 with an empty FIFO and the FSM in IDLE gives key_out high during the cycle after edge E0+1.
- **Pointers:** wrap modulo DEPTH. Occupancy runs 0..DEPTH inclusive.
- **Outputs:** key_out and err are registered. busy and key_ready are combinational from registers.

Test Plan:
1. Reset, then push code 2 at E0 → key_out=26'h0000004 for exactly the one cycle after E1; then 0. busy falls after the gap expires. count returns to 0.
2. GAP=2, push 0,1,25 on consecutive edges → three pulses 26'h0000001, 26'h0000002, 26'h2000000, each one cycle wide. Exactly 2 zero cycles separate each pair. Order is preserved.
3. DEPTH=4, hold key_valid with codes 3,4,5,6,7 → key_ready drops when count=4 and the fifth code stalls. The fifth code is accepted on the first edge after a pop makes count<4. All five pulse in order.
4. Push code 26, then code 31 → both handshakes complete. err pulses one cycle after each. No key_out activity. count stays 0.
5. GAP=0, push 10 and 11 back-to-back → key_out=26'h0000400 then 26'h0000800 in adjacent cycles, then 0.
6. Assert resetn=0 during the FIRE cycle with 2 entries queued → key_out=0 and count=0 after that edge. No further pulses occur after release. key_ready=1.
